// File: rtl/riscv_ctrl_aludec_mseq.sv
// ALU control decoder with optional RV32M decode and multi-cycle sequencing.
// Base integer ops decode combinationally. MUL*/DIV*/REM* issue a one-cycle
// start pulse and hold decode stalled until the M-unit result is due.

`ifndef RISCV_ALU_ADD_OP
`define RISCV_ALU_ADD_OP  4'b0000
`endif
`ifndef RISCV_ALU_SL_OP
`define RISCV_ALU_SL_OP   4'b0001
`endif
`ifndef RISCV_ALU_SLT_OP
`define RISCV_ALU_SLT_OP  4'b0010
`endif
`ifndef RISCV_ALU_SLTU_OP
`define RISCV_ALU_SLTU_OP 4'b0011
`endif
`ifndef RISCV_ALU_XOR_OP
`define RISCV_ALU_XOR_OP  4'b0100
`endif
`ifndef RISCV_ALU_SR_OP
`define RISCV_ALU_SR_OP   4'b0101
`endif
`ifndef RISCV_ALU_OR_OP
`define RISCV_ALU_OR_OP   4'b0110
`endif
`ifndef RISCV_ALU_AND_OP
`define RISCV_ALU_AND_OP  4'b0111
`endif
`ifndef RISCV_ALU_SUB_OP
`define RISCV_ALU_SUB_OP  4'b1000
`endif
`ifndef RISCV_ALU_SRA_OP
`define RISCV_ALU_SRA_OP  4'b1101
`endif

module riscv_ctrl_aludec_mseq #(
    parameter int CTRL_W  = 5,
    parameter int MEXT_EN = 1,
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 33
) (
    input  logic              iclk,
    input  logic              irst,
    input  logic              ivalid,
    input  logic              iflush,
    input  logic [1:0]        ialu_op,
    input  logic              iop_b5,
    input  logic [2:0]        ifunct3,
    input  logic              ifunct7_b5,
    input  logic              ifunct7_b0,
    output logic [CTRL_W-1:0] oalu_ctrl,
    output logic [1:0]        ounit_sel,
    output logic              ostart,
    output logic              ostall,
    output logic              odone,
    output logic              obusy
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = (MAX_LAT < 1) ? 1 : $clog2(MAX_LAT + 1);
    // Counter preload is LAT-2: the issue cycle and the done cycle are not counted.
    localparam int MUL_LD  = (MUL_LAT > 1) ? MUL_LAT - 2 : 0;
    localparam int DIV_LD  = (DIV_LAT > 1) ? DIV_LAT - 2 : 0;
    localparam bit MEXT    = (MEXT_EN != 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_MBUSY = 2'b01,
        S_DBUSY = 2'b10
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CTRL_W-1:0]   lctrl_q, lctrl_d;
    logic [1:0]          lunit_q, lunit_d;

    logic [3:0]          base_code;
    logic                mop;
    logic                is_div;
    logic                lat_one;
    logic                issue;
    logic [CTRL_W-1:0]   mcode;
    logic [1:0]          munit;

    assign mop     = MEXT & ialu_op[1] & iop_b5 & ifunct7_b0;
    assign is_div  = ifunct3[2];
    assign lat_one = is_div ? (DIV_LAT == 1) : (MUL_LAT == 1);
    // M-op codes are 16 + funct3.
    assign mcode   = CTRL_W'({2'b10, ifunct3});
    assign munit   = is_div ? 2'b10 : 2'b01;
    assign issue   = (state_q == S_IDLE) & ivalid & mop & ~iflush & ~irst;

    // Base-ISA funct decode
    always_comb begin
        base_code = `RISCV_ALU_ADD_OP;
        if (!ialu_op[1]) begin
            base_code = ialu_op[0] ? `RISCV_ALU_SUB_OP : `RISCV_ALU_ADD_OP;
        end else begin
            case (ifunct3)
                3'b000:  base_code = (ifunct7_b5 & iop_b5) ? `RISCV_ALU_SUB_OP : `RISCV_ALU_ADD_OP;
                3'b001:  base_code = `RISCV_ALU_SL_OP;
                3'b010:  base_code = `RISCV_ALU_SLT_OP;
                3'b011:  base_code = `RISCV_ALU_SLTU_OP;
                3'b100:  base_code = `RISCV_ALU_XOR_OP;
                3'b101:  base_code = ifunct7_b5 ? `RISCV_ALU_SRA_OP : `RISCV_ALU_SR_OP;
                3'b110:  base_code = `RISCV_ALU_OR_OP;
                default: base_code = `RISCV_ALU_AND_OP;
            endcase
        end
    end

    // State, counter and latched-op registers
    always_ff @(posedge iclk) begin
        if (irst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            lctrl_q <= '0;
            lunit_q <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lctrl_q <= lctrl_d;
            lunit_q <= lunit_d;
        end
    end

    // Next-state: issue multi-cycle ops, count down while busy, abort on flush
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lctrl_d = lctrl_q;
        lunit_d = lunit_q;
        case (state_q)
            S_IDLE: begin
                // Single-cycle M-ops finish in the issue cycle and never leave IDLE.
                if (issue && !lat_one) begin
                    state_d = is_div ? S_DBUSY : S_MBUSY;
                    cnt_d   = is_div ? CNT_W'(DIV_LD) : CNT_W'(MUL_LD);
                    lctrl_d = mcode;
                    lunit_d = munit;
                end
            end
            S_MBUSY, S_DBUSY: begin
                if (cnt_q == '0) state_d = S_IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        if (iflush || !MEXT) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end
    end

    // Outputs: combinational decode in IDLE, latched op while busy
    always_comb begin
        oalu_ctrl = CTRL_W'(base_code);
        ounit_sel = 2'b00;
        ostart    = 1'b0;
        ostall    = 1'b0;
        odone     = 1'b0;
        obusy     = 1'b0;
        case (state_q)
            S_MBUSY, S_DBUSY: begin
                oalu_ctrl = lctrl_q;
                ounit_sel = lunit_q;
                obusy     = 1'b1;
                ostall    = (cnt_q != '0);
                odone     = (cnt_q == '0);
            end
            default: begin
                if (mop) begin
                    oalu_ctrl = mcode;
                    ounit_sel = munit;
                    if (ivalid) begin
                        ostart = 1'b1;
                        ostall = ~lat_one;
                        odone  = lat_one;
                    end
                end
            end
        endcase
        if (iflush) begin
            ostart = 1'b0;
            ostall = 1'b0;
            odone  = 1'b0;
        end
        // Reset cycle shows no handshake activity, so an op hit by reset never reports done.
        if (irst || !MEXT) begin
            ostart = 1'b0;
            ostall = 1'b0;
            odone  = 1'b0;
            obusy  = 1'b0;
        end
    end

endmodule

// File: tb/tb_riscv_ctrl_aludec_mseq.sv
// Bench for riscv_ctrl_aludec_mseq: three configurations share one input bus
// (default, base-only, single-cycle MUL) and are checked every cycle against a
// cycle-number based reference model, plus directed checks from the test plan.

module tb_riscv_ctrl_aludec_mseq;

    // Expected base-op codes
    localparam int C_ADD = 0, C_SL = 1, C_SLT = 2, C_SLTU = 3, C_XOR = 4;
    localparam int C_SR = 5, C_OR = 6, C_AND = 7, C_SUB = 8, C_SRA = 13;

    logic iclk = 1'b0;
    always #5 iclk = ~iclk;

    logic       irst, ivalid, iflush, iop_b5, ifunct7_b5, ifunct7_b0;
    logic [1:0] ialu_op;
    logic [2:0] ifunct3;

    logic [4:0] ctrl0;  logic [7:0] ctrl1;  logic [5:0] ctrl2;
    logic [1:0] unit0, unit1, unit2;
    logic       start0, start1, start2, stall0, stall1, stall2;
    logic       done0, done1, done2, busy0, busy1, busy2;

    riscv_ctrl_aludec_mseq #(.CTRL_W(5), .MEXT_EN(1), .MUL_LAT(2), .DIV_LAT(33)) u_dut0 (
        .iclk(iclk), .irst(irst), .ivalid(ivalid), .iflush(iflush), .ialu_op(ialu_op),
        .iop_b5(iop_b5), .ifunct3(ifunct3), .ifunct7_b5(ifunct7_b5), .ifunct7_b0(ifunct7_b0),
        .oalu_ctrl(ctrl0), .ounit_sel(unit0), .ostart(start0), .ostall(stall0),
        .odone(done0), .obusy(busy0));

    riscv_ctrl_aludec_mseq #(.CTRL_W(8), .MEXT_EN(0), .MUL_LAT(2), .DIV_LAT(33)) u_dut1 (
        .iclk(iclk), .irst(irst), .ivalid(ivalid), .iflush(iflush), .ialu_op(ialu_op),
        .iop_b5(iop_b5), .ifunct3(ifunct3), .ifunct7_b5(ifunct7_b5), .ifunct7_b0(ifunct7_b0),
        .oalu_ctrl(ctrl1), .ounit_sel(unit1), .ostart(start1), .ostall(stall1),
        .odone(done1), .obusy(busy1));

    riscv_ctrl_aludec_mseq #(.CTRL_W(6), .MEXT_EN(1), .MUL_LAT(1), .DIV_LAT(4)) u_dut2 (
        .iclk(iclk), .irst(irst), .ivalid(ivalid), .iflush(iflush), .ialu_op(ialu_op),
        .iop_b5(iop_b5), .ifunct3(ifunct3), .ifunct7_b5(ifunct7_b5), .ifunct7_b0(ifunct7_b0),
        .oalu_ctrl(ctrl2), .ounit_sel(unit2), .ostart(start2), .ostall(stall2),
        .odone(done2), .obusy(busy2));

    logic [31:0] act_ctrl [3];
    logic [1:0]  act_unit [3];
    logic        act_start[3], act_stall[3], act_done[3], act_busy[3];
    assign act_ctrl[0] = 32'(ctrl0); assign act_ctrl[1] = 32'(ctrl1); assign act_ctrl[2] = 32'(ctrl2);
    assign act_unit[0] = unit0;  assign act_unit[1] = unit1;  assign act_unit[2] = unit2;
    assign act_start[0] = start0; assign act_start[1] = start1; assign act_start[2] = start2;
    assign act_stall[0] = stall0; assign act_stall[1] = stall1; assign act_stall[2] = stall2;
    assign act_done[0] = done0;  assign act_done[1] = done1;  assign act_done[2] = done2;
    assign act_busy[0] = busy0;  assign act_busy[1] = busy1;  assign act_busy[2] = busy2;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference model: an in-flight M-op is a held code plus the cycle number
    // on which its result is due; nothing else is remembered.
    int p_mext[3] = '{1, 0, 1};
    int p_mlat[3] = '{2, 2, 1};
    int p_dlat[3] = '{33, 33, 4};
    bit m_act [3];
    int m_code[3], m_unit[3], m_due[3], m_lat[3];
    bit m_iss [3];
    int cyc = 0;

    function automatic int base_op();
        if (!ialu_op[1]) return ialu_op[0] ? C_SUB : C_ADD;
        case (ifunct3)
            3'd0: return (ifunct7_b5 && iop_b5) ? C_SUB : C_ADD;
            3'd1: return C_SL;
            3'd2: return C_SLT;
            3'd3: return C_SLTU;
            3'd4: return C_XOR;
            3'd5: return ifunct7_b5 ? C_SRA : C_SR;
            3'd6: return C_OR;
            default: return C_AND;
        endcase
    endfunction

    // Compare all three DUTs against the model mid-cycle
    task automatic sample();
        @(negedge iclk);
        for (int k = 0; k < 3; k++) begin
            int e_ctrl, e_unit;
            bit e_st, e_sl, e_dn, e_bz, mop;
            e_st = 0; e_sl = 0; e_dn = 0; e_bz = 0;
            mop = (p_mext[k] != 0) && ialu_op[1] && iop_b5 && ifunct7_b0;
            m_iss[k] = 0;
            if (m_act[k]) begin
                e_ctrl = m_code[k]; e_unit = m_unit[k]; e_bz = 1;
                e_sl = (cyc < m_due[k]);
                e_dn = (cyc == m_due[k]);
            end else if (mop) begin
                e_ctrl = 16 + int'(ifunct3);
                e_unit = ifunct3[2] ? 2 : 1;
                m_lat[k] = ifunct3[2] ? p_dlat[k] : p_mlat[k];
                m_iss[k] = ivalid && !iflush && !irst;
                e_st = ivalid;
                e_sl = ivalid && (m_lat[k] > 1);
                e_dn = ivalid && (m_lat[k] == 1);
            end else begin
                e_ctrl = base_op(); e_unit = 0;
            end
            if (iflush) begin e_st = 0; e_sl = 0; e_dn = 0; end
            if (irst) begin e_st = 0; e_sl = 0; e_dn = 0; e_bz = 0; end
            chk($sformatf("k%0d ctrl", k),  act_ctrl[k], e_ctrl);
            chk($sformatf("k%0d unit", k),  32'(act_unit[k]), e_unit);
            chk($sformatf("k%0d start", k), 32'(act_start[k]), 32'(e_st));
            chk($sformatf("k%0d stall", k), 32'(act_stall[k]), 32'(e_sl));
            chk($sformatf("k%0d done", k),  32'(act_done[k]), 32'(e_dn));
            chk($sformatf("k%0d busy", k),  32'(act_busy[k]), 32'(e_bz));
        end
    endtask

    // Advance one clock and update the model with the inputs of that cycle
    task automatic adv();
        @(posedge iclk);
        for (int k = 0; k < 3; k++) begin
            if (irst || iflush) m_act[k] = 0;
            else if (m_act[k]) begin
                if (cyc == m_due[k]) m_act[k] = 0;
            end else if (m_iss[k] && m_lat[k] > 1) begin
                m_act[k]  = 1;
                m_code[k] = 16 + int'(ifunct3);
                m_unit[k] = ifunct3[2] ? 2 : 1;
                m_due[k]  = cyc + m_lat[k] - 1;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic setin(input bit v, input bit f, input int op, input bit b5,
                         input int f3, input bit f7b5, input bit f7b0);
        ivalid = v; iflush = f; ialu_op = 2'(op); iop_b5 = b5;
        ifunct3 = 3'(f3); ifunct7_b5 = f7b5; ifunct7_b0 = f7b0;
    endtask

    task automatic scramble();
        ialu_op = 2'($urandom); ifunct3 = 3'($urandom); ivalid = 1'($urandom);
        iop_b5 = 1'($urandom); ifunct7_b5 = 1'($urandom); ifunct7_b0 = 1'($urandom);
    endtask

    int nstall, done_at;

    initial begin
        irst = 1; setin(1, 0, 2, 1, 0, 0, 1);
        for (int k = 0; k < 3; k++) m_act[k] = 0;
        sample(); adv(); sample(); adv();
        irst = 0;

        // Reset state and base decode
        setin(0, 0, 2, 1, 0, 1, 0);
        sample();
        chk("rst busy", 32'(busy0), 0);
        chk("rst stall", 32'(stall0), 0);
        chk("sub", 32'(ctrl0), C_SUB);
        adv();
        setin(0, 0, 2, 0, 0, 1, 0); sample(); chk("add", 32'(ctrl0), C_ADD); adv();
        setin(0, 0, 2, 1, 5, 1, 0); sample(); chk("sra", 32'(ctrl0), C_SRA); adv();

        // MUL, two-cycle on dut0; base-only ADD on dut1; single-cycle on dut2
        setin(1, 0, 2, 1, 0, 0, 1);
        sample();
        chk("mul t0 ctrl", 32'(ctrl0), 16);
        chk("mul t0 unit", 32'(unit0), 1);
        chk("mul t0 start", 32'(start0), 1);
        chk("mul t0 stall", 32'(stall0), 1);
        chk("nomext ctrl", 32'(ctrl1), C_ADD);
        chk("nomext stall", 32'(stall1), 0);
        chk("lat1 start", 32'(start2), 1);
        chk("lat1 done", 32'(done2), 1);
        chk("lat1 stall", 32'(stall2), 0);
        adv();
        sample();
        chk("mul t1 stall", 32'(stall0), 0);
        chk("mul t1 done", 32'(done0), 1);
        chk("mul t1 busy", 32'(busy0), 1);
        chk("mul t1 restart", 32'(start0), 0);
        adv();
        ivalid = 0;
        sample(); chk("mul t2 busy", 32'(busy0), 0); adv();

        // DIVU: 32 stall cycles then done, latched op stable under random inputs
        setin(1, 0, 2, 1, 5, 0, 1);
        nstall = 0; done_at = -1;
        for (int i = 0; i < 40 && done_at < 0; i++) begin
            if (i > 0) scramble();
            sample();
            chk("divu ctrl", 32'(ctrl0), 21);
            chk("divu unit", 32'(unit0), 2);
            if (stall0) nstall++;
            if (done0) done_at = i;
            adv();
        end
        chk("divu stalls", 32'(nstall), 32);
        chk("divu done at", 32'(done_at), 32);

        // Flush at T5 of DIV, then a fresh MUL
        setin(1, 0, 2, 1, 4, 0, 1);
        for (int i = 0; i < 5; i++) begin sample(); adv(); end
        iflush = 1;
        sample(); chk("flush stall", 32'(stall0), 0); chk("flush done", 32'(done0), 0); adv();
        setin(0, 0, 0, 0, 0, 0, 0);
        sample(); chk("flush idle", 32'(busy0), 0); adv();
        setin(1, 0, 2, 1, 0, 0, 1);
        sample(); chk("post-flush start", 32'(start0), 1); adv();
        sample(); chk("post-flush done", 32'(done0), 1); adv();

        // Reset at T3 of DIV
        setin(1, 0, 2, 1, 6, 0, 1);
        for (int i = 0; i < 3; i++) begin sample(); adv(); end
        irst = 1; sample(); adv(); irst = 0; ivalid = 0;
        sample();
        chk("rst-mid busy", 32'(busy0), 0);
        chk("rst-mid stall", 32'(stall0), 0);
        chk("rst-mid done", 32'(done0), 0);
        adv();

        // DIV then MUL presented right after the DIV's done
        setin(1, 0, 2, 1, 7, 0, 1);
        done_at = -1;
        for (int i = 0; i < 40 && done_at < 0; i++) begin
            sample();
            if (i > 0) chk("b2b no restart", 32'(start0), 0);
            if (done0) done_at = i;
            adv();
        end
        chk("b2b div done", 32'(done_at), 32);
        setin(1, 0, 2, 1, 1, 0, 1);
        sample(); chk("b2b mul start", 32'(start0), 1); chk("b2b mul ctrl", 32'(ctrl0), 17); adv();
        ivalid = 0; sample(); adv();

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            scramble();
            ivalid = ($urandom_range(0, 7) != 0);
            iflush = ($urandom_range(0, 40) == 0);
            irst   = ($urandom_range(0, 150) == 0);
            sample(); adv();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/riscv_ctrl_aludec_mseq.md
Name: riscv_ctrl_aludec_mseq

Overview:
- ALU control decoder, second generation. Parametrised control width; optional RV32M decode; multi-cycle sequencing for MUL/DIV/REM.
- Sits in the control unit beside the main decoder.
- Drives the ALU/M-unit operation select and a decode-stage stall while a multi-cycle M-op executes.
- Base integer ops decode combinationally with zero added latency.

Parameters:
- CTRL_W, 5: width of oalu_ctrl; must be >= 5.
- MEXT_EN, 1: 1 enables RV32M decode and sequencing; 0 treats funct7_b0 as don't-care (base-ISA behaviour only).
- MUL_LAT, 2: total cycles a MUL* op occupies decode, >= 1.
- DIV_LAT, 33: total cycles a DIV*/REM* op occupies decode, >= 1.

Ports:
- iclk  input  1  clock
- irst  input  1  synchronous active-high reset
- ivalid  input  1  instruction in decode is valid
- iflush  input  1  pipeline flush; aborts any M-op in flight
- ialu_op  input  2  main-decoder ALU op class (00 add, 01 sub/branch, 1x funct-decoded)
- iop_b5  input  1  opcode bit 5 (1 = R-type)
- ifunct3  input  3  instruction funct3
- ifunct7_b5  input  1  funct7 bit 5
- ifunct7_b0  input  1  funct7 bit 0 (M-extension marker)
- oalu_ctrl  output  CTRL_W  operation select
- ounit_sel  output  2  00 ALU, 01 multiplier, 10 divider
- ostart  output  1  one-cycle start pulse to the M-unit
- ostall  output  1  hold fetch/decode
- odone  output  1  one-cycle pulse: M-op result valid this cycle
- obusy  output  1  FSM not IDLE

Behaviour:
- Control encoding:
  - Base ops = existing 4-bit `RISCV_ALU_*_OP codes, zero-extended to CTRL_W.
  - M ops = 16 + funct3: MUL 16, MULH 17, MULHSU 18, MULHU 19, DIV 20, DIVU 21, REM 22, REMU 23.
- Base decode (combinational):
  - ialu_op 00 -> ADD; 01 -> SUB.
  - ialu_op 1x, by funct3:
    - 000 -> SUB if (funct7_b5 & op_b5), else ADD.
    - 001 SL; 010 SLT; 011 SLTU; 100 XOR.
    - 101 -> SRA if funct7_b5, else SR.
    - 110 OR; 111 AND.
- M-op detect: mop = MEXT_EN & ialu_op[1] & iop_b5 & ifunct7_b0. mop takes priority over the funct7_b5 checks. mop with funct3[2]=0 is MUL class; funct3[2]=1 is DIV class.
- FSM states: IDLE, MBUSY, DBUSY. Down-counter cnt is $clog2(max(MUL_LAT,DIV_LAT)+1) bits wide.
- Base ops in IDLE:
  - oalu_ctrl = decoded base code; ounit_sel=00.
  - ostall=0, ostart=0, odone=0.
  - ivalid is not required for the decode value.
- Issue cycle T0 (state IDLE & ivalid & mop & !iflush):
  - All T0 outputs are combinational: ostart=1; oalu_ctrl = M code; ounit_sel = 01 or 10.
  - ostall=1, unless LAT==1, in which case ostall=0 and odone=1 in T0. The FSM stays IDLE; there are no busy cycles.
  - LAT>1: latch oalu_ctrl/ounit_sel into a register, load cnt = LAT-2, go to MBUSY/DBUSY at T0+1.
- Busy states:
  - Outputs come from the latched register. Inputs ialu_op/funct*/ivalid are ignored.
  - ostall=1 while cnt!=0; cnt decrements each cycle.
  - When cnt==0: ostall=0, odone=1, next state IDLE.
  - The stall therefore covers cycles T0..T0+LAT-2; odone is at T0+LAT-1.
  - The held instruction is still presented in the odone cycle. It must not re-issue, because the FSM is not IDLE that cycle.
  - obusy=1 in MBUSY/DBUSY only.
- iflush:
  - In any state, forces ostall=0, ostart=0, odone=0 that cycle; next state IDLE; cnt cleared.
  - Flush in T0 suppresses issue entirely.
- ivalid=0 with mop in IDLE: oalu_ctrl shows the M code, but ostart=0, ostall=0, no state change.
- Reset (irst sampled at posedge):
  - State IDLE, cnt=0, latch=0.
  - ostall, ostart, odone, obusy = 0.
  - Reset mid-operation aborts with no odone.
- MEXT_EN=0: FSM is constant IDLE; ostart, ostall, odone, obusy are tied 0; ounit_sel=00.

Test Plan:
- Base ops: ialu_op=10, op_b5=1, funct3=000, f7b5=1, f7b0=0 -> oalu_ctrl={0,`RISCV_ALU_SUB_OP}, ostall=0. Repeat with op_b5=0 -> ADD. funct3=101 with f7b5=1 -> SRA.
- MUL, MUL_LAT=2: ivalid, R-type, f7b0=1, funct3=000 -> T0: oalu_ctrl=16, ounit_sel=01, ostart=1, ostall=1. T1: ostall=0, odone=1, obusy=1. T2: IDLE, obusy=0.
- DIVU, DIV_LAT=33: funct3=101 -> ostall high exactly 32 cycles (T0..T31), odone at T32. oalu_ctrl=21 and ounit_sel=10 stable throughout; randomised ialu_op/funct3 during busy has no effect.
- Flush at T5 of DIV -> ostall=0 at T5, no odone, IDLE at T6. A new MUL issued at T6 starts normally.
- irst at T3 of DIV -> all outputs 0 next cycle. A back-to-back DIV then MUL (MUL presented at the DIV's odone+1) issues correctly with no double start.
- MEXT_EN=0 or MUL_LAT=1: f7b0=1, funct3=000, R-type -> MEXT_EN=0 gives ADD code with no stall; MUL_LAT=1 gives ostart=1 and odone=1 in the same cycle, with ostall=0.
